pipe_wb_chain: RTL and testbench

- Parametrised successor of the single-stage MEM/WB register: a chain of STAGES write-back pipeline registers.
- Carries the valid/write-enable/dest-register/write-data bundle.
- Adds stall, flush, occupancy count and a youngest-match forwarding lookup for the hazard unit.
- Sits between the MEM stage and the register file; with STAGES=1 it is the plain MEM/WB register plus control.

---
 rtl/pipe_wb_chain.sv | 144 ++++++++++++++
 tb/tb_pipe_wb_chain.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wb_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_wb_chain
// Description : STAGES-deep MEM/WB register chain with stall, flush,
//               occupancy count and youngest-match forwarding lookup.
//               Optional macro PIPE_WB_TRACE_EN adds pc/have_inst trace ports.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_chain #(
    parameter int STAGES = 1,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              rf_we_i,
    input  logic [ADDR_W-1:0] wR_i,
    input  logic [DATA_W-1:0] wD_i,
    output logic              valid_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] wR_o,
    output logic [DATA_W-1:0] wD_o,
    output logic [CNT_W-1:0]  count_o,
`ifdef PIPE_WB_TRACE_EN
    input  logic [31:0]       pc_i,
    output logic [31:0]       pc_o,
    input  logic              have_inst_i,
    output logic              have_inst_o,
`endif
    input  logic [ADDR_W-1:0] rR_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic              st_valid [STAGES];
    logic              st_we    [STAGES];
    logic [ADDR_W-1:0] st_wr    [STAGES];
    logic [DATA_W-1:0] st_wd    [STAGES];
`ifdef PIPE_WB_TRACE_EN
    logic [31:0]       st_pc    [STAGES];
    logic              st_hi    [STAGES];
`endif

    // Forwarding priority chain; index STAGES is the "no match" terminator.
    logic              sel_hit  [STAGES+1];
    logic [DATA_W-1:0] sel_data [STAGES+1];
    logic [CNT_W-1:0]  count;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic              src_valid;
            logic              src_we;
            logic [ADDR_W-1:0] src_wr;
            logic [DATA_W-1:0] src_wd;
            logic              match;
`ifdef PIPE_WB_TRACE_EN
            logic [31:0]       src_pc;
            logic              src_hi;
`endif

            if (k == 0) begin : g_head
                assign src_valid = valid_i;
                assign src_we    = valid_i & rf_we_i;
                assign src_wr    = wR_i;
                assign src_wd    = wD_i;
`ifdef PIPE_WB_TRACE_EN
                assign src_pc    = pc_i;
                assign src_hi    = have_inst_i;
`endif
            end else begin : g_body
                assign src_valid = st_valid[k-1];
                assign src_we    = st_we[k-1];
                assign src_wr    = st_wr[k-1];
                assign src_wd    = st_wd[k-1];
`ifdef PIPE_WB_TRACE_EN
                assign src_pc    = st_pc[k-1];
                assign src_hi    = st_hi[k-1];
`endif
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    st_valid[k] <= 1'b0;
                    st_we[k]    <= 1'b0;
                    st_wr[k]    <= '0;
                    st_wd[k]    <= '0;
`ifdef PIPE_WB_TRACE_EN
                    st_pc[k]    <= '0;
                    st_hi[k]    <= 1'b0;
`endif
                end else if (flush_i) begin
                    // Payload is left in place; only the qualifiers are dropped.
                    st_valid[k] <= 1'b0;
                    st_we[k]    <= 1'b0;
`ifdef PIPE_WB_TRACE_EN
                    st_hi[k]    <= 1'b0;
`endif
                end else if (!stall_i) begin
                    st_valid[k] <= src_valid;
                    st_we[k]    <= src_we;
                    st_wr[k]    <= src_wr;
                    st_wd[k]    <= src_wd;
`ifdef PIPE_WB_TRACE_EN
                    st_pc[k]    <= src_pc;
                    st_hi[k]    <= src_hi;
`endif
                end
            end

            assign match       = st_valid[k] & st_we[k] & (st_wr[k] == rR_i) & (rR_i != '0);
            assign sel_hit[k]  = match | sel_hit[k+1];
            assign sel_data[k] = match ? st_wd[k] : sel_data[k+1];
        end
    endgenerate

    assign sel_hit[STAGES]  = 1'b0;
    assign sel_data[STAGES] = '0;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count <= '0;
        end else if (!stall_i) begin
            count <= count + CNT_W'(valid_i) - CNT_W'(st_valid[STAGES-1]);
        end
    end

    assign valid_o    = st_valid[STAGES-1];
    assign rf_we_o    = st_valid[STAGES-1] & st_we[STAGES-1];
    assign wR_o       = st_wr[STAGES-1];
    assign wD_o       = st_wd[STAGES-1];
    assign count_o    = count;
    assign fwd_hit_o  = sel_hit[0];
    assign fwd_data_o = sel_data[0];
`ifdef PIPE_WB_TRACE_EN
    assign pc_o        = st_pc[STAGES-1];
    assign have_inst_o = st_valid[STAGES-1] & st_hi[STAGES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_wb_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_wb_chain
// Description : Directed self-checking bench for pipe_wb_chain with STAGES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_wb_chain;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic        rf_we_i;
    logic [4:0]  wR_i;
    logic [31:0] wD_i;
    logic        valid_o;
    logic        rf_we_o;
    logic [4:0]  wR_o;
    logic [31:0] wD_o;
    logic [3:0]  count_o;
    logic [4:0]  rR_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
`ifdef PIPE_WB_TRACE_EN
    logic [31:0] pc_i;
    logic [31:0] pc_o;
    logic        have_inst_i;
    logic        have_inst_o;
`endif

    int checks = 0;
    int errors = 0;

    pipe_wb_chain #(
        .STAGES (3),
        .DATA_W (32),
        .ADDR_W (5),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .rf_we_i    (rf_we_i),
        .wR_i       (wR_i),
        .wD_i       (wD_i),
        .valid_o    (valid_o),
        .rf_we_o    (rf_we_o),
        .wR_o       (wR_o),
        .wD_o       (wD_o),
        .count_o    (count_o),
`ifdef PIPE_WB_TRACE_EN
        .pc_i       (pc_i),
        .pc_o       (pc_o),
        .have_inst_i(have_inst_i),
        .have_inst_o(have_inst_o),
`endif
        .rR_i       (rR_i),
        .fwd_hit_o  (fwd_hit_o),
        .fwd_data_o (fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] r, input logic [31:0] d);
        valid_i = v;
        rf_we_i = we;
        wR_i    = r;
        wD_i    = d;
`ifdef PIPE_WB_TRACE_EN
        pc_i        = {27'h0, r} + 32'h1000;
        have_inst_i = v;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'h1234);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rR_i = 5'd5;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0h exp 0", rf_we_o); end
        checks++; if (wR_o !== 5'd0) begin errors++; $display("FAIL reset_wR got %0h exp 0", wR_o); end
        checks++; if (wD_o !== 32'd0) begin errors++; $display("FAIL reset_wD got %0h exp 0", wD_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if (fwd_hit_o !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got %0h exp 0", fwd_hit_o); end
        checks++; if (fwd_data_o !== 32'd0) begin errors++; $display("FAIL reset_fwd_data got %0h exp 0", fwd_data_o); end
    endtask

    // One bundle in, visible at the output after the third edge for one cycle.
    task automatic test_latency();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            step();
            drive(1'b0, 1'b0, 5'd0, 32'h0);
            checks++; if (valid_o !== (cyc == 3)) begin errors++; $display("FAIL lat_valid cyc %0d got %0h exp %0h", cyc, valid_o, (cyc == 3)); end
            checks++; if (count_o !== ((cyc <= 3) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL lat_count cyc %0d got %0d exp %0d", cyc, count_o, (cyc <= 3) ? 1 : 0); end
            if (cyc == 3) begin
                checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL lat_rf_we got %0h exp 1", rf_we_o); end
                checks++; if (wR_o !== 5'd5) begin errors++; $display("FAIL lat_wR got %0h exp 5", wR_o); end
                checks++; if (wD_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_wD got %0h exp deadbeef", wD_o); end
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        drive(1'b1, 1'b1, 5'd1, 32'hA1); step();
        drive(1'b1, 1'b1, 5'd2, 32'hB2); step();
        drive(1'b1, 1'b1, 5'd3, 32'hC3); step();
        checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", count_o); end
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd15, 32'hFF);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (wR_o !== 5'd1 || wD_o !== 32'hA1 || valid_o !== 1'b1) begin errors++; $display("FAIL stall_out cyc %0d got %0h/%0h/%0h exp 1/1/a1", i, valid_o, wR_o, wD_o); end
            checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL stall_count cyc %0d got %0d exp 3", i, count_o); end
        end
        stall_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        step();
        checks++; if (wR_o !== 5'd2 || wD_o !== 32'hB2 || valid_o !== 1'b1 || count_o !== 4'd2) begin errors++; $display("FAIL drain_b got %0h/%0h/%0h cnt %0d exp 1/2/b2 cnt 2", valid_o, wR_o, wD_o, count_o); end
        step();
        checks++; if (wR_o !== 5'd3 || wD_o !== 32'hC3 || valid_o !== 1'b1 || count_o !== 4'd1) begin errors++; $display("FAIL drain_c got %0h/%0h/%0h cnt %0d exp 1/3/c3 cnt 1", valid_o, wR_o, wD_o, count_o); end
        step();
        checks++; if (valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL drain_end got %0h cnt %0d exp 0 cnt 0", valid_o, count_o); end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 1'b1, 5'd4, 32'h44); step();
        drive(1'b1, 1'b1, 5'd6, 32'h66); step();
        checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL fl_pre_count got %0d exp 2", count_o); end
        flush_i = 1'b1;
        stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd8, 32'h88);
        step();
        flush_i = 1'b0;
        stall_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", count_o); end
        checks++; if (valid_o !== 1'b0 || rf_we_o !== 1'b0) begin errors++; $display("FAIL fl_out got %0h/%0h exp 0/0", valid_o, rf_we_o); end
        rR_i = 5'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (valid_o !== 1'b0 || rf_we_o !== 1'b0 || count_o !== 4'd0 || fwd_hit_o !== 1'b0) begin errors++; $display("FAIL fl_drop cyc %0d got %0h/%0h cnt %0d hit %0h exp 0/0 cnt 0 hit 0", i, valid_o, rf_we_o, count_o, fwd_hit_o); end
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 1'b1, 5'd7, 32'h22); step();
        drive(1'b1, 1'b1, 5'd3, 32'h33); step();
        drive(1'b1, 1'b1, 5'd7, 32'h11); step();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rR_i = 5'd7; #1;
        checks++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h11) begin errors++; $display("FAIL fwd_young got %0h/%0h exp 1/11", fwd_hit_o, fwd_data_o); end
        rR_i = 5'd3; #1;
        checks++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h33) begin errors++; $display("FAIL fwd_mid got %0h/%0h exp 1/33", fwd_hit_o, fwd_data_o); end
        rR_i = 5'd12; #1;
        checks++; if (fwd_hit_o !== 1'b0 || fwd_data_o !== 32'h0) begin errors++; $display("FAIL fwd_miss got %0h/%0h exp 0/0", fwd_hit_o, fwd_data_o); end
        // Stages now: s0=(0,55) s1=(7,11) s2=(3,33)
        drive(1'b1, 1'b1, 5'd0, 32'h55); step();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rR_i = 5'd0; #1;
        checks++; if (fwd_hit_o !== 1'b0 || fwd_data_o !== 32'h0) begin errors++; $display("FAIL fwd_zero got %0h/%0h exp 0/0", fwd_hit_o, fwd_data_o); end
        stall_i = 1'b1;
        flush_i = 1'b1;
        rR_i = 5'd7; #1;
        checks++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h11) begin errors++; $display("FAIL fwd_same_cycle got %0h/%0h exp 1/11", fwd_hit_o, fwd_data_o); end
        step();
        stall_i = 1'b0;
        flush_i = 1'b0;
        checks++; if (fwd_hit_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL fwd_after_flush got %0h cnt %0d exp 0 cnt 0", fwd_hit_o, count_o); end
    endtask

    task automatic test_invalid_write();
        drive(1'b0, 1'b1, 5'd9, 32'h99);
        rR_i = 5'd9;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (rf_we_o !== 1'b0 || fwd_hit_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL inv_write cyc %0d got we %0h hit %0h cnt %0d exp 0 0 0", i, rf_we_o, fwd_hit_o, count_o); end
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd10, 32'hAAAA); step();
        drive(1'b1, 1'b1, 5'd11, 32'hBBBB); step();
        drive(1'b1, 1'b1, 5'd12, 32'hCCCC); step();
        checks++; if (count_o !== 4'd3 || valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got cnt %0d valid %0h exp 3/1", count_o, valid_o); end
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd13, 32'hDDDD);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rR_i = 5'd12; #1;
        checks++; if (valid_o !== 1'b0 || rf_we_o !== 1'b0 || wR_o !== 5'd0 || wD_o !== 32'd0) begin errors++; $display("FAIL rmid_out got %0h/%0h/%0h/%0h exp 0/0/0/0", valid_o, rf_we_o, wR_o, wD_o); end
        checks++; if (count_o !== 4'd0 || fwd_hit_o !== 1'b0) begin errors++; $display("FAIL rmid_count got cnt %0d hit %0h exp 0/0", count_o, fwd_hit_o); end
`ifdef PIPE_WB_TRACE_EN
        checks++; if (pc_o !== 32'd0 || have_inst_o !== 1'b0) begin errors++; $display("FAIL rmid_trace got %0h/%0h exp 0/0", pc_o, have_inst_o); end
`endif
    endtask

    initial begin
        rst     = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        rR_i    = 5'd0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_latency();
        test_back_to_back_stall();
        test_flush_stall();
        test_forward();
        test_invalid_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
